delayed_branch_sched: RTL and testbench
=======================================

# delayed_branch_sched

Scheduler for the two delayed-branch slots produced by the branch generation unit. It captures the p0/p1 delayed-branch words and condition codes as they leave S1, carries them alongside the pipeline to the S3 flag point, and evaluates each condition against N/V/Z. On a true condition it re-injects the stored branch word into the fetch stage through `p0_do_delayed_B`/`p1_do_delayed_B`, flushes younger work, and suppresses capture until the pipeline drains.

## Interface
- `DEPTH`, 2: advances from S1 capture to the S3 evaluation slot (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (`rst`=0 resets).
- `adv` in 1: pipeline advance (`fetch_next`); 0 freezes all entries and the FSM.
- `halted` in 1: system halted; blocks capture and firing.
- `p0_delayed_B_in` in 16: p0 delayed word, {head[15:8], dest[7:0]}.
- `p0_delayed_cond_in` in 3: p0 condition; NV(0) marks no entry.
- `p1_delayed_B_in` in 16: p1 delayed word.
- `p1_delayed_cond_in` in 3: p1 condition.
- `N`, `V`, `Z` in 1 each: S3 flags.
- `flags_valid` in 1: flags are final for the instruction in the evaluation slot.
- `p0_do_delayed_B` out 1: inject `inject_IR` into p0 this cycle.
- `p1_do_delayed_B` out 1: inject `inject_IR` into p1 this cycle.
- `inject_IR` out 16: stored word of the firing entry.
- `flush_pipe` out 1: kill S1..S3 younger work; one cycle.
- `stall_req` out 1: hold the pipeline; evaluation is waiting on flags.
- `busy` out 1: FSM is not in IDLE.

## Operation
- Entry = {valid, word[15:0], cond[2:0]} per slot. The shift chain is DEPTH deep × 2 slots. Capture valid = (cond≠NV).
- Condition truth: NV=0, AL=1, EQ=Z, NE=~Z, LT=N^V, LE=(N^V)|Z, GT=~((N^V)|Z), GE=~(N^V).
- FSM, 3 states:
  - **IDLE**
    - On `adv`=1 the chain shifts and the new S1 pair is captured.
    - Evaluate when the eval slot has any valid entry, `adv`=1 and `flags_valid`=1.
    - p0 is older and wins: if p0 is true, p1 is discarded. If only p1 is true, p1 fires.
    - If neither is true, the entries retire silently.
    - On a win: latch the word and slot, then go to FIRE.
  - **FIRE**
    - Assert `flush_pipe` (first cycle only), `inject_IR`, and the `pX_do_delayed_B` for the latched slot.
    - Hold the do/inject outputs until `adv`=1, then load the drain counter with DEPTH and go to DRAIN.
    - All chain entries are cleared on entry to FIRE.
  - **DRAIN**
    - Inputs are ignored and no capture happens.
    - The counter decrements on each `adv`=1. At 0 the FSM goes to IDLE, and capture resumes on that same edge.
- `stall_req` = IDLE & eval slot valid & ~`flags_valid`. It is combinational.
- `halted`=1: no capture, no evaluation, and FIRE does not start. If already in FIRE/DRAIN, the sequence completes. A HALT_immediately word (head 001_00_111, cond AL) fires normally before `halted` rises.
- Drain counter width = $clog2(DEPTH+1). It is never decremented below 0.

## Timing
- Reset values: all entries invalid, FSM=IDLE, counter=0, every output 0, `inject_IR`=16'h0000.
- A word captured at edge k (with `adv`) sits in the eval slot after DEPTH-1 further `adv` edges. With `adv` constant 1 it is evaluated in cycle k+DEPTH-1.
- Evaluation edge → FIRE outputs visible the next cycle (1-cycle registered latency).
- Minimum FIRE length is 1 cycle. It stretches for every `adv`=0 cycle.
- Capture and evaluation on the same edge: shift and evaluation use pre-edge contents. The slot leaving eval is the one judged.
- `adv`=0 in IDLE: nothing changes. `stall_req` may still be asserted.
- Reset mid-FIRE/DRAIN: asynchronous return to the reset values, with no partial injection.

## Structure
- Package `bgu_pkg`:
  - cond localparams NV..GE
  - HALT head constant 8'b001_00_111
  - typedef `dly_entry_t`
  - function `cond_true(cond,N,V,Z)`
- Sub-module `dly_shift_chain`: DEPTH-deep, 2-wide entry chain with shift, capture and clear. The FSM and evaluation stay in the top.

## Test plan
- p0 word 16'h2012, cond EQ, `adv`=1, Z=1 at eval → after DEPTH-1 more cycles, FIRE: `p0_do_delayed_B`=1, `inject_IR`=16'h2012, `flush_pipe`=1 for 1 cycle.
- p0 cond LT (N=0, V=0) plus p1 cond GE (N=0, V=0) in the same slot → p1 fires, `p1_do_delayed_B`=1, `p0_do_delayed_B`=0.
- p0 cond AL and p1 cond AL together → only p0 fires. p1's word never appears on `inject_IR`.
- Entry at eval with `flags_valid`=0 for 3 cycles → `stall_req`=1 for exactly those 3 cycles; the FSM stays in IDLE until flags are valid.
- FIRE with `adv`=0 for 2 cycles → do/inject held 3 cycles, `flush_pipe` asserted 1 cycle. DRAIN then ignores conds for DEPTH advances.
- `rst`=0 pulse asynchronously mid-DRAIN → all outputs 0 immediately. After release, a new EQ/Z=1 capture fires normally.

Source files
------------

// File: rtl/bgu_pkg.sv
// Shared types and condition logic for the delayed-branch scheduler.
// No latency or flow control of its own; consumed by the chain and the FSM.
package bgu_pkg;

    localparam logic [2:0] COND_NV = 3'd0;
    localparam logic [2:0] COND_AL = 3'd1;
    localparam logic [2:0] COND_EQ = 3'd2;
    localparam logic [2:0] COND_NE = 3'd3;
    localparam logic [2:0] COND_LT = 3'd4;
    localparam logic [2:0] COND_LE = 3'd5;
    localparam logic [2:0] COND_GT = 3'd6;
    localparam logic [2:0] COND_GE = 3'd7;

    localparam logic [7:0] HALT_HEAD = 8'b001_00_111;

    typedef struct packed {
        logic        vld;
        logic [15:0] word;
        logic [2:0]  cond;
    } dly_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_DRAIN
    } sched_state_t;

    function automatic logic cond_true(input logic [2:0] cond, input logic n,
                                       input logic v, input logic z);
        logic lt;
        lt = n ^ v;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_LT: cond_true = lt;
            COND_LE: cond_true = lt | z;
            COND_GT: cond_true = ~(lt | z);
            COND_GE: cond_true = ~lt;
            default: cond_true = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/delayed_branch_sched_if.sv
// Pipeline-side signals of the delayed-branch scheduler: S1 capture, S3 flags, fetch injection.
// Purely combinational bundle; adv is the only flow control and comes from the pipeline.
interface delayed_branch_sched_if;
    logic        adv;
    logic        halted;
    logic [15:0] p0_delayed_B_in;
    logic [2:0]  p0_delayed_cond_in;
    logic [15:0] p1_delayed_B_in;
    logic [2:0]  p1_delayed_cond_in;
    logic        N;
    logic        V;
    logic        Z;
    logic        flags_valid;
    logic        p0_do_delayed_B;
    logic        p1_do_delayed_B;
    logic [15:0] inject_IR;
    logic        flush_pipe;
    logic        stall_req;
    logic        busy;

    modport master (
        output adv, halted, p0_delayed_B_in, p0_delayed_cond_in,
               p1_delayed_B_in, p1_delayed_cond_in, N, V, Z, flags_valid,
        input  p0_do_delayed_B, p1_do_delayed_B, inject_IR, flush_pipe,
               stall_req, busy
    );

    modport slave (
        input  adv, halted, p0_delayed_B_in, p0_delayed_cond_in,
               p1_delayed_B_in, p1_delayed_cond_in, N, V, Z, flags_valid,
        output p0_do_delayed_B, p1_do_delayed_B, inject_IR, flush_pipe,
               stall_req, busy
    );
endinterface

// File: rtl/dly_shift_chain.sv
// DEPTH-deep, two-slot chain carrying delayed-branch entries from S1 to the S3 eval slot; DEPTH-shift latency.
// Moves only when shift_i is high; clr_i empties every stage and overrides a shift.
module dly_shift_chain
    import bgu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_i,
    input  logic       clr_i,
    input  dly_entry_t p0_i,
    input  dly_entry_t p1_i,
    output dly_entry_t p0_o,
    output dly_entry_t p1_o
);

    dly_entry_t p0_q [DEPTH];
    dly_entry_t p1_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                p0_q[i] <= '0;
                p1_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                p0_q[i] <= '0;
                p1_q[i] <= '0;
            end
        end else if (shift_i) begin
            p0_q[0] <= p0_i;
            p1_q[0] <= p1_i;
            for (int i = 1; i < DEPTH; i++) begin
                p0_q[i] <= p0_q[i-1];
                p1_q[i] <= p1_q[i-1];
            end
        end
    end

    assign p0_o = p0_q[DEPTH-1];
    assign p1_o = p1_q[DEPTH-1];

endmodule

// File: rtl/delayed_branch_sched.sv
// Evaluates delayed-branch slots at S3 and re-injects the winner into fetch; FIRE outputs one cycle after the eval edge.
// Frozen by adv=0; requests a stall while the eval slot waits on flags; ignores S1 until the pipe has drained.
module delayed_branch_sched
    import bgu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    delayed_branch_sched_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    sched_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0] inj_q, inj_d;
    logic slot_q, slot_d;
    logic flush_q, flush_d;

    dly_entry_t cap0, cap1, ev0, ev1;
    logic shift_en, cap_en, clr, stall;
    logic eval_any, p0_true, p1_true;

    assign cap0 = {cap_en && (bus.p0_delayed_cond_in != COND_NV),
                   bus.p0_delayed_B_in, bus.p0_delayed_cond_in};
    assign cap1 = {cap_en && (bus.p1_delayed_cond_in != COND_NV),
                   bus.p1_delayed_B_in, bus.p1_delayed_cond_in};

    dly_shift_chain #(.DEPTH(DEPTH)) u_chain (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_en),
        .clr_i   (clr),
        .p0_i    (cap0),
        .p1_i    (cap1),
        .p0_o    (ev0),
        .p1_o    (ev1)
    );

    assign eval_any = ev0.vld | ev1.vld;
    assign p0_true  = ev0.vld & cond_true(ev0.cond, bus.N, bus.V, bus.Z);
    assign p1_true  = ev1.vld & cond_true(ev1.cond, bus.N, bus.V, bus.Z);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inj_d    = inj_q;
        slot_d   = slot_q;
        flush_d  = 1'b0;
        shift_en = 1'b0;
        cap_en   = 1'b0;
        clr      = 1'b0;
        stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = eval_any & ~bus.flags_valid;
                // The chain holds while stalled so the waiting entry is judged, not dropped.
                if (bus.adv && !stall) begin
                    shift_en = 1'b1;
                    cap_en   = ~bus.halted;
                    if (!bus.halted && (p0_true || p1_true)) begin
                        clr     = 1'b1;
                        inj_d   = p0_true ? ev0.word : ev1.word;
                        slot_d  = ~p0_true;
                        flush_d = 1'b1;
                        state_d = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                if (bus.adv) begin
                    cnt_d   = CNT_W'(DEPTH);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.adv) begin
                    if (cnt_q == '0) begin
                        state_d  = ST_IDLE;
                        shift_en = 1'b1;
                        cap_en   = ~bus.halted;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inj_q   <= '0;
            slot_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inj_q   <= inj_d;
            slot_q  <= slot_d;
            flush_q <= flush_d;
        end
    end

    assign bus.p0_do_delayed_B = (state_q == ST_FIRE) & ~slot_q;
    assign bus.p1_do_delayed_B = (state_q == ST_FIRE) &  slot_q;
    assign bus.inject_IR       = (state_q == ST_FIRE) ? inj_q : 16'h0000;
    assign bus.flush_pipe      = (state_q == ST_FIRE) & flush_q;
    assign bus.stall_req       = stall;
    assign bus.busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_delayed_branch_sched.sv
// Scoreboard bench for delayed_branch_sched: stimulus queues expected fire cycles, a negedge monitor checks them.
module tb_delayed_branch_sched;
    import bgu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        int          cyc;
        logic        p0;
        logic        p1;
        logic [15:0] word;
        logic        flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q [$];

    delayed_branch_sched_if b ();

    delayed_branch_sched #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every cycle the DUT drives an injection or flush must match the queue head.
    always @(negedge clk) begin
        if (rst && (b.p0_do_delayed_B || b.p1_do_delayed_B || b.flush_pipe)) begin
            exp_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_fire: got cyc=%0d p0=%0b p1=%0b ir=%h fl=%0b, expected no injection",
                         cyc, b.p0_do_delayed_B, b.p1_do_delayed_B, b.inject_IR, b.flush_pipe);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.p0 !== b.p0_do_delayed_B || e.p1 !== b.p1_do_delayed_B ||
                    e.word !== b.inject_IR || e.flush !== b.flush_pipe) begin
                    n_bad++;
                    $display("FAIL fire: got cyc=%0d p0=%0b p1=%0b ir=%h fl=%0b, expected cyc=%0d p0=%0b p1=%0b ir=%h fl=%0b",
                             cyc, b.p0_do_delayed_B, b.p1_do_delayed_B, b.inject_IR, b.flush_pipe,
                             e.cyc, e.p0, e.p1, e.word, e.flush);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fire(input int at, input logic p1, input logic [15:0] w, input logic fl);
        exp_t e;
        e.cyc = at; e.p0 = ~p1; e.p1 = p1; e.word = w; e.flush = fl;
        exp_q.push_back(e);
    endtask

    // Drives one S1 pair for a single adv edge; returns with cyc equal to that capture edge.
    task automatic issue(input logic [15:0] w0, input logic [2:0] c0,
                         input logic [15:0] w1, input logic [2:0] c1);
        b.p0_delayed_B_in = w0; b.p0_delayed_cond_in = c0;
        b.p1_delayed_B_in = w1; b.p1_delayed_cond_in = c1;
        step();
        b.p0_delayed_cond_in = COND_NV;
        b.p1_delayed_cond_in = COND_NV;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!b.busy) break;
            step();
        end
        chk("idle_reached", 32'(b.busy), 32'd0);
    endtask

    task automatic run_fire(input string name);
        repeat (DEPTH) step();
        chk(name, 32'(b.busy), 32'd1);
        wait_idle();
    endtask

    logic [15:0] halt_word;
    int f;

    initial begin
        b.adv = 1'b1; b.halted = 1'b0; b.flags_valid = 1'b1;
        b.N = 1'b0; b.V = 1'b0; b.Z = 1'b0;
        b.p0_delayed_B_in = '0; b.p0_delayed_cond_in = COND_NV;
        b.p1_delayed_B_in = '0; b.p1_delayed_cond_in = COND_NV;
        halt_word = {HALT_HEAD, 8'h40};

        #2 rst = 1'b0;
        #1;
        chk("rst_p0_do", 32'(b.p0_do_delayed_B), 32'd0);
        chk("rst_p1_do", 32'(b.p1_do_delayed_B), 32'd0);
        chk("rst_inject", 32'(b.inject_IR), 32'h0);
        chk("rst_flush", 32'(b.flush_pipe), 32'd0);
        chk("rst_stall", 32'(b.stall_req), 32'd0);
        chk("rst_busy", 32'(b.busy), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        step();

        // p0 EQ with Z=1
        b.Z = 1'b1;
        issue(16'h2012, COND_EQ, 16'h0000, COND_NV);
        expect_fire(cyc + DEPTH, 1'b0, 16'h2012, 1'b1);
        run_fire("eq_fire_busy");

        // p0 LT false, p1 GE true
        b.N = 1'b0; b.V = 1'b0; b.Z = 1'b0;
        issue(16'h1111, COND_LT, 16'h2222, COND_GE);
        expect_fire(cyc + DEPTH, 1'b1, 16'h2222, 1'b1);
        run_fire("p1_fire_busy");

        // both AL: p0 wins
        issue(16'h3333, COND_AL, 16'h4444, COND_AL);
        expect_fire(cyc + DEPTH, 1'b0, 16'h3333, 1'b1);
        run_fire("al_fire_busy");

        // neither true: retire silently
        b.N = 1'b1; b.V = 1'b1; b.Z = 1'b0;
        issue(16'h5150, COND_EQ, 16'h5151, COND_LT);
        repeat (DEPTH + 3) step();
        chk("no_fire_busy", 32'(b.busy), 32'd0);

        // flags not ready for 3 cycles
        b.N = 1'b0; b.V = 1'b0;
        b.flags_valid = 1'b0;
        issue(16'h5555, COND_AL, 16'h0000, COND_NV);
        repeat (DEPTH - 1) step();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            chk("stall_on", 32'(b.stall_req), 32'd1);
            chk("stall_idle", 32'(b.busy), 32'd0);
        end
        b.flags_valid = 1'b1;
        #1;
        chk("stall_off", 32'(b.stall_req), 32'd0);
        expect_fire(cyc + 1, 1'b0, 16'h5555, 1'b1);
        step();
        chk("stall_fire_busy", 32'(b.busy), 32'd1);
        wait_idle();

        // FIRE stretched by two adv=0 cycles, then DRAIN ignores conds
        issue(16'h6666, COND_AL, 16'h0000, COND_NV);
        f = cyc + DEPTH;
        expect_fire(f, 1'b0, 16'h6666, 1'b1);
        expect_fire(f + 1, 1'b0, 16'h6666, 1'b0);
        expect_fire(f + 2, 1'b0, 16'h6666, 1'b0);
        repeat (DEPTH) step();
        b.adv = 1'b0;
        step();
        step();
        b.adv = 1'b1;
        step();
        b.p0_delayed_B_in = 16'h7777; b.p0_delayed_cond_in = COND_AL;
        step();
        step();
        b.p0_delayed_cond_in = COND_NV;
        chk("drain_last_busy", 32'(b.busy), 32'd1);
        step();
        chk("drain_exit_busy", 32'(b.busy), 32'd0);
        repeat (DEPTH + 2) step();

        // HALT word fires, then halted blocks capture
        issue(halt_word, COND_AL, 16'h0000, COND_NV);
        expect_fire(cyc + DEPTH, 1'b0, halt_word, 1'b1);
        repeat (DEPTH) step();
        b.halted = 1'b1;
        chk("halt_fire_busy", 32'(b.busy), 32'd1);
        wait_idle();
        issue(16'h9999, COND_AL, 16'h0000, COND_NV);
        repeat (DEPTH + 3) step();
        chk("halted_busy", 32'(b.busy), 32'd0);
        b.halted = 1'b0;
        repeat (DEPTH + 2) step();

        // async reset in DRAIN, then normal operation
        issue(16'hAAAA, COND_AL, 16'h0000, COND_NV);
        expect_fire(cyc + DEPTH, 1'b0, 16'hAAAA, 1'b1);
        repeat (DEPTH + 1) step();
        chk("pre_rst_busy", 32'(b.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(b.busy), 32'd0);
        chk("mid_rst_p0_do", 32'(b.p0_do_delayed_B), 32'd0);
        chk("mid_rst_inject", 32'(b.inject_IR), 32'h0);
        chk("mid_rst_flush", 32'(b.flush_pipe), 32'd0);
        step();
        step();
        rst = 1'b1;
        b.Z = 1'b1;
        issue(16'hBBBB, COND_EQ, 16'h0000, COND_NV);
        expect_fire(cyc + DEPTH, 1'b0, 16'hBBBB, 1'b1);
        run_fire("post_rst_fire_busy");
        repeat (3) step();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
